// File: rtl/ops_pkg.sv
// Shared IDDMM datapath constants: normalised word width, redundant sum width,
// words per operand, carry register width and the worst-case carry value.
package ops_pkg;

  localparam int unsigned WORD_W    = 128;
  localparam int unsigned SUM_W     = WORD_W + 2;
  localparam int unsigned NWORDS    = 32;
  localparam int unsigned CW        = 3;
  localparam int unsigned CARRY_MAX = 4;

endpackage : ops_pkg

// File: rtl/carry_norm_stream.sv
// Word-serial carry normaliser placed after the pipelined 129-bit adder.
// Takes redundant SUM_W-bit sum words (LS word first), folds the running carry
// into each one, and emits canonical WORD_W-bit words with the final carry-out
// attached to the last word of each NUM_WORDS-word operand.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    input handshake, in_sum is the redundant sum word
//   out_valid/out_ready  output handshake for out_word/out_last/out_carry
//   out_last             marks word NUM_WORDS-1 of the operand
//   out_carry            operand carry-out, nonzero only alongside out_last
//   busy                 operand in flight (word 0 accepted .. last word taken)
module carry_norm_stream #(
  parameter int unsigned NUM_WORDS = ops_pkg::NWORDS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ops_pkg::SUM_W-1:0] in_sum,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ops_pkg::WORD_W-1:0] out_word,
  output logic                      out_last,
  output logic [ops_pkg::CW-1:0]    out_carry,
  output logic                      busy
);

  import ops_pkg::*;

  localparam int unsigned CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned T_W   = SUM_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

  logic [CW-1:0]    carry;
  logic [CNT_W-1:0] cnt;
  logic [T_W-1:0]   t;
  logic [CW-1:0]    new_carry;
  logic             accept;
  logic             out_take;
  logic             is_last;

  // Single output register, no skid: accept whenever the register is free
  // or being drained this cycle.
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_take  = out_valid && out_ready;
  assign is_last   = (cnt == LAST_CNT);

  // Carry never exceeds 4, so the upper T_W-WORD_W bits fit the carry register.
  assign t         = T_W'(in_sum) + T_W'(carry);
  assign new_carry = t[T_W-1:WORD_W];

  // Add-and-register datapath with word counter and busy tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_word  <= '0;
      out_last  <= 1'b0;
      out_carry <= '0;
      busy      <= 1'b0;
      carry     <= '0;
      cnt       <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_word  <= t[WORD_W-1:0];
        if (is_last) begin
          // Operand boundary: publish carry-out, restart fresh with no idle cycle.
          out_last  <= 1'b1;
          out_carry <= new_carry;
          carry     <= '0;
          cnt       <= '0;
        end else begin
          out_last  <= 1'b0;
          out_carry <= '0;
          carry     <= new_carry;
          cnt       <= cnt + CNT_W'(1);
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // Starting a new operand wins over finishing the previous one.
      if (accept && (cnt == '0)) begin
        busy <= 1'b1;
      end else if (out_take && out_last) begin
        busy <= 1'b0;
      end
    end
  end

endmodule : carry_norm_stream

// File: tb/tb_carry_norm_stream.sv
// Directed self-checking bench for carry_norm_stream with 4-word operands.
// Inputs change 1 time unit after the rising edge; registered outputs are
// checked at the same point, after the edge that produced them.
module tb_carry_norm_stream;

  import ops_pkg::*;

  localparam int unsigned NW = 4;

  localparam logic [SUM_W-1:0] P128  = SUM_W'(1) << 128;
  localparam logic [SUM_W-1:0] P129  = SUM_W'(1) << 129;
  localparam logic [SUM_W-1:0] ONES  = P128 - SUM_W'(1);
  localparam logic [SUM_W-1:0] SMAX  = {2'b11, {127{1'b1}}, 1'b0};
  localparam logic [SUM_W-1:0] ONESM = P128 - SUM_W'(2);

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [SUM_W-1:0]  in_sum;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_word;
  logic              out_last;
  logic [CW-1:0]     out_carry;
  logic              busy;

  int vectors;
  int miscompares;

  carry_norm_stream #(.NUM_WORDS(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_last  (out_last),
    .out_carry (out_carry),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [SUM_W-1:0] obs,
                     input logic [SUM_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full check of the output register contents plus busy.
  task automatic chk_out(input string tag, input logic [SUM_W-1:0] word,
                         input logic last, input logic [CW-1:0] carry,
                         input logic bsy);
    chk({tag, ".valid"}, SUM_W'(out_valid), SUM_W'(1));
    chk({tag, ".word"},  SUM_W'(out_word),  word);
    chk({tag, ".last"},  SUM_W'(out_last),  SUM_W'(last));
    chk({tag, ".carry"}, SUM_W'(out_carry), SUM_W'(carry));
    chk({tag, ".busy"},  SUM_W'(busy),      SUM_W'(bsy));
  endtask

  task automatic drive(input logic [SUM_W-1:0] s);
    in_valid = 1'b1;
    in_sum   = s;
    tick();
  endtask

  task automatic go_idle(input string tag);
    in_valid = 1'b0;
    in_sum   = '0;
    tick();
    chk({tag, ".idle_valid"}, SUM_W'(out_valid), SUM_W'(0));
    chk({tag, ".idle_busy"},  SUM_W'(busy),      SUM_W'(0));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_sum      = '0;
    out_ready   = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst.valid",    SUM_W'(out_valid), SUM_W'(0));
    chk("rst.word",     SUM_W'(out_word),  SUM_W'(0));
    chk("rst.last",     SUM_W'(out_last),  SUM_W'(0));
    chk("rst.carry",    SUM_W'(out_carry), SUM_W'(0));
    chk("rst.busy",     SUM_W'(busy),      SUM_W'(0));
    chk("rst.in_ready", SUM_W'(in_ready),  SUM_W'(1));

    // 1: all-zero operand, 1-cycle latency, last on word 3
    in_valid = 1'b1;
    in_sum   = '0;
    #1;
    chk("s1.pre_valid", SUM_W'(out_valid), SUM_W'(0));
    tick();
    chk_out("s1.w0", '0, 1'b0, '0, 1'b1);
    drive('0); chk_out("s1.w1", '0, 1'b0, '0, 1'b1);
    drive('0); chk_out("s1.w2", '0, 1'b0, '0, 1'b1);
    drive('0); chk_out("s1.w3", '0, 1'b1, '0, 1'b1);
    go_idle("s1");

    // 2: carry ripple, carries 2,1,1,0
    drive(P129);            chk_out("s2.w0", '0,         1'b0, '0, 1'b1);
    drive(ONES);            chk_out("s2.w1", SUM_W'(1),  1'b0, '0, 1'b1);
    drive(ONES);            chk_out("s2.w2", '0,         1'b0, '0, 1'b1);
    drive('0);              chk_out("s2.w3", SUM_W'(1),  1'b1, '0, 1'b1);
    go_idle("s2");

    // 3: max redundant sums; carries 3,4,4,4 and carry-out at the bound
    drive(SMAX);            chk_out("s3.w0", ONESM,      1'b0, '0, 1'b1);
    drive(SMAX);            chk_out("s3.w1", SUM_W'(1),  1'b0, '0, 1'b1);
    drive(SMAX);            chk_out("s3.w2", SUM_W'(2),  1'b0, '0, 1'b1);
    drive(SMAX);            chk_out("s3.w3", SUM_W'(2),  1'b1, CW'(CARRY_MAX), 1'b1);
    go_idle("s3");

    // 4: backpressure for 3 cycles after word 1
    drive(SUM_W'(5));        chk_out("s4.w0", SUM_W'(5), 1'b0, '0, 1'b1);
    drive(P128 + SUM_W'(7)); chk_out("s4.w1", SUM_W'(7), 1'b0, '0, 1'b1);
    out_ready = 1'b0;
    in_sum    = SUM_W'(10);
    #1;
    chk("s4.stall_ready0", SUM_W'(in_ready), SUM_W'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("s4.hold", SUM_W'(7), 1'b0, '0, 1'b1);
      chk("s4.stall_ready", SUM_W'(in_ready), SUM_W'(0));
    end
    out_ready = 1'b1;
    tick();
    chk_out("s4.w2", SUM_W'(11), 1'b0, '0, 1'b1);
    drive(P129 + SUM_W'(3)); chk_out("s4.w3", SUM_W'(3), 1'b1, CW'(2), 1'b1);
    go_idle("s4");

    // 5: reset after word 2 discards the partial operand and its carry
    drive(P129);             chk_out("s5.w0", '0,        1'b0, '0, 1'b1);
    drive(P129 + SUM_W'(1)); chk_out("s5.w1", SUM_W'(3), 1'b0, '0, 1'b1);
    drive(P129);             chk_out("s5.w2", SUM_W'(2), 1'b0, '0, 1'b1);
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    chk("s5.rst_valid", SUM_W'(out_valid), SUM_W'(0));
    chk("s5.rst_word",  SUM_W'(out_word),  SUM_W'(0));
    chk("s5.rst_busy",  SUM_W'(busy),      SUM_W'(0));
    drive(SUM_W'(9));        chk_out("s5.n0", SUM_W'(9), 1'b0, '0, 1'b1);
    drive('0);               chk_out("s5.n1", '0,        1'b0, '0, 1'b1);
    drive('0);               chk_out("s5.n2", '0,        1'b0, '0, 1'b1);
    drive('0);               chk_out("s5.n3", '0,        1'b1, '0, 1'b1);
    go_idle("s5");

    // 6: back-to-back operands; B starts with zero carry, busy stays high
    drive('0);               chk_out("s6.a0", '0,        1'b0, '0, 1'b1);
    drive('0);               chk_out("s6.a1", '0,        1'b0, '0, 1'b1);
    drive('0);               chk_out("s6.a2", '0,        1'b0, '0, 1'b1);
    drive(P128 + P129);      chk_out("s6.a3", '0,        1'b1, CW'(3), 1'b1);
    drive(SUM_W'(5));        chk_out("s6.b0", SUM_W'(5), 1'b0, '0, 1'b1);
    drive('0);               chk_out("s6.b1", '0,        1'b0, '0, 1'b1);
    drive('0);               chk_out("s6.b2", '0,        1'b0, '0, 1'b1);
    drive(SUM_W'(1));        chk_out("s6.b3", SUM_W'(1), 1'b1, '0, 1'b1);
    go_idle("s6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_carry_norm_stream
